// File: rtl/uart_tx_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_serializer
// Purpose  : UART transmit engine. Serialises one parallel word per frame:
//            start bit, DATA_WIDTH data bits LSB-first, optional even/odd
//            parity bit, then one or two stop bits. Bit time comes from an
//            internal prescale counter, so no external baud tick is needed.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Data_Valid,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      busy,
    output logic                      ser_done,
    output logic                      TX_OUT
);

    // Bit index must be able to hold 0..DATA_WIDTH.
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Current-state registers
    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] presc_cnt;
    logic [PRESCALE_WIDTH-1:0] peff;
    logic [BIT_W-1:0]          bit_idx;
    logic                      stop_idx;
    logic [DATA_WIDTH-1:0]     shreg;
    logic                      par_bit;
    logic                      par_en_q;
    logic                      stop2_q;
    logic                      tx_q;
    logic                      busy_q;
    logic                      done_q;

    // Next-state values
    state_t                    state_n;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_n;
    logic [PRESCALE_WIDTH-1:0] peff_n;
    logic [BIT_W-1:0]          bit_idx_n;
    logic                      stop_idx_n;
    logic [DATA_WIDTH-1:0]     shreg_n;
    logic                      par_bit_n;
    logic                      par_en_n;
    logic                      stop2_n;
    logic                      tx_n;
    logic                      busy_n;
    logic                      done_n;

    // Helpers
    logic [PRESCALE_WIDTH-1:0] prescale_eff;
    logic                      bit_end;

    // A zero prescale would never end a bit, so it is promoted to one.
    assign prescale_eff = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
    // Last cycle of the current bit time (counter has reached Peff-1).
    assign bit_end      = (presc_cnt == (peff - PRESCALE_WIDTH'(1)));

    // State register: every piece of frame state, cleared asynchronously so
    // the line returns high the moment RST rises.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            presc_cnt <= '0;
            peff      <= PRESCALE_WIDTH'(1);
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            presc_cnt <= presc_cnt_n;
            peff      <= peff_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            shreg     <= shreg_n;
            par_bit   <= par_bit_n;
            par_en_q  <= par_en_n;
            stop2_q   <= stop2_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_n     = state;
        presc_cnt_n = bit_end ? '0 : presc_cnt + PRESCALE_WIDTH'(1);
        peff_n      = peff;
        bit_idx_n   = bit_idx;
        stop_idx_n  = stop_idx;
        shreg_n     = shreg;
        par_bit_n   = par_bit;
        par_en_n    = par_en_q;
        stop2_n     = stop2_q;
        tx_n        = tx_q;
        busy_n      = busy_q;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                presc_cnt_n = '0;
                tx_n        = 1'b1;
                busy_n      = 1'b0;
                if (Data_Valid) begin
                    // Snapshot everything the frame depends on; later input
                    // changes cannot disturb the frame in flight.
                    shreg_n    = P_DATA;
                    par_bit_n  = (^P_DATA) ^ PAR_TYP;
                    par_en_n   = PAR_EN;
                    stop2_n    = STOP2;
                    peff_n     = prescale_eff;
                    bit_idx_n  = '0;
                    stop_idx_n = 1'b0;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                    state_n    = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            tx_n    = par_bit;
                            state_n = S_PARITY;
                        end else begin
                            tx_n       = 1'b1;
                            stop_idx_n = 1'b0;
                            state_n    = S_STOP;
                        end
                    end else begin
                        bit_idx_n = bit_idx + BIT_W'(1);
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    tx_n       = 1'b1;
                    stop_idx_n = 1'b0;
                    state_n    = S_STOP;
                end
            end

            S_STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (stop2_q && !stop_idx) begin
                        stop_idx_n = 1'b1;
                    end else begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end

            default: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign TX_OUT   = tx_q;
    assign busy     = busy_q;
    assign ser_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame_serializer
// Purpose  : Directed self-checking bench for uart_tx_frame_serializer.
//            Expected frames are hand-written bit strings (first bit on the
//            line is bit 0 of the vector).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_serializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Data_Valid = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       STOP2 = 1'b0;
    logic [7:0] Prescale = 8'd1;
    logic       busy;
    logic       ser_done;
    logic       TX_OUT;

    int total = 0;
    int bad   = 0;

    uart_tx_frame_serializer #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .P_DATA     (P_DATA),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .Prescale   (Prescale),
        .busy       (busy),
        .ser_done   (ser_done),
        .TX_OUT     (TX_OUT)
    );

    always #5 CLK = ~CLK;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic start_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                               input logic s2, input logic [7:0] presc);
        @(posedge CLK); #1;
        P_DATA = data; PAR_EN = pen; PAR_TYP = ptyp; STOP2 = s2; Prescale = presc;
        Data_Valid = 1'b1;
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
    endtask

    // Sample the line on every falling edge while busy, until ser_done.
    task automatic capture_frame(input string tag, input logic [15:0] bits,
                                 input int nbits, input int peff);
        int  n;
        int  errs;
        int  guard;
        bit  done;
        n = 0; errs = 0; guard = 0; done = 1'b0;
        while (!done && guard < 4000) begin
            @(negedge CLK);
            guard++;
            if (ser_done) begin
                done = 1'b1;
                check({tag, "_sd_line_busy"}, {30'd0, TX_OUT, busy}, 32'd2);
            end else if (busy) begin
                if (n < nbits * peff) begin
                    if (TX_OUT !== bits[n / peff]) errs++;
                end
                n++;
            end
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_cycles"}, n, nbits * peff);
        check({tag, "_bit_errors"}, errs, 0);
    endtask

    // Watchdog: the run must always end on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sd_cnt;
        int busy_cnt;

        // ---------------- reset state ----------------
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_tx", {31'd0, TX_OUT}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, ser_done}, 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_tx", {31'd0, TX_OUT}, 32'd1);

        // ---------------- 1: 0xA5, P=4, 8N1 ----------------
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4);
        check("t1_first_cycle_busy_tx", {30'd0, busy, TX_OUT}, 32'd2);
        capture_frame("t1", 16'b1101001010, 10, 4);
        @(negedge CLK);
        check("t1_done_one_cycle", {31'd0, ser_done}, 32'd0);

        // ---------------- 2: parity even / odd, P=2 ----------------
        start_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8'd2);
        capture_frame("t2_even", 16'b10101001010, 11, 2);
        start_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'd2);
        capture_frame("t2_odd", 16'b11101001010, 11, 2);

        // ---------------- 3: 0x00 odd parity, 2 stop, P=0 and P=1 ----------------
        start_frame(8'h00, 1'b1, 1'b1, 1'b1, 8'd0);
        capture_frame("t3_p0", 16'b111000000000, 12, 1);
        start_frame(8'h00, 1'b1, 1'b1, 1'b1, 8'd1);
        capture_frame("t3_p1", 16'b111000000000, 12, 1);

        // ---------------- 4: request while busy is ignored ----------------
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4);
        fork
            capture_frame("t4", 16'b1101001010, 10, 4);
            begin
                repeat (10) @(posedge CLK);
                #1;
                P_DATA = 8'h3C; PAR_EN = 1'b1; STOP2 = 1'b1; Prescale = 8'd1; PAR_TYP = 1'b1;
                Data_Valid = 1'b1;
                @(posedge CLK); #1;
                Data_Valid = 1'b0;
            end
        join
        sd_cnt = 0; busy_cnt = 0;
        repeat (60) begin
            @(negedge CLK);
            if (ser_done) sd_cnt++;
            if (busy) busy_cnt++;
        end
        check("t4_extra_done", sd_cnt, 0);
        check("t4_extra_busy", busy_cnt, 0);

        // ---------------- 5: Data_Valid held, back-to-back ----------------
        @(posedge CLK); #1;
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; Prescale = 8'd2;
        Data_Valid = 1'b1;
        @(posedge CLK); #1;
        P_DATA = 8'h0F;
        capture_frame("t5_f1", 16'b1010101010, 10, 2);
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        check("t5_gap_then_start", {30'd0, busy, TX_OUT}, 32'd2);
        capture_frame("t5_f2", 16'b1000011110, 10, 2);

        // ---------------- 6: reset during data bit 3 ----------------
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4);
        repeat (17) @(negedge CLK);
        check("t6_pre_rst_bit3", {30'd0, busy, TX_OUT}, 32'd2);
        RST = 1'b1;
        #1;
        check("t6_rst_tx_async", {31'd0, TX_OUT}, 32'd1);
        check("t6_rst_busy_async", {31'd0, busy}, 32'd0);
        sd_cnt = 0;
        repeat (3) begin
            @(negedge CLK);
            if (ser_done) sd_cnt++;
        end
        RST = 1'b0;
        repeat (50) begin
            @(negedge CLK);
            if (ser_done) sd_cnt++;
        end
        check("t6_no_done", sd_cnt, 0);
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4);
        capture_frame("t6_after", 16'b1101001010, 10, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame_serializer.md
Name: uart_tx_frame_serializer

Overview:
Parametrised UART transmit engine that generates a complete frame from a parallel word. A frame is a start bit, DATA_WIDTH data bits sent LSB-first, an optional even or odd parity bit, and 1 or 2 stop bits. It has an internal per-bit prescale counter, so no external baud tick is needed. It sits between the TX data source (FIFO or register interface) and the TX pad, and drives the line directly.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESCALE_WIDTH, 8, width of the runtime Prescale port.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
Data_Valid  input  1  request to transmit P_DATA; sampled only while busy=0.
P_DATA  input  DATA_WIDTH  word to transmit.
PAR_EN  input  1  1 = insert parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP2  input  1  1 = two stop bits, 0 = one stop bit.
Prescale  input  PRESCALE_WIDTH  CLK cycles per bit; 0 is treated as 1.
busy  output  1  high from frame acceptance until the last stop bit completes.
ser_done  output  1  one-cycle pulse when a frame completes.
TX_OUT  output  1  serial line; idles high.

Behaviour:
- Reset (RST=1, asynchronous): TX_OUT=1, busy=0, ser_done=0, state=IDLE, all counters cleared. Asserting RST mid-frame aborts the frame and forces TX_OUT high immediately, without waiting for a clock edge. Nothing is retained after reset.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - On an edge with Data_Valid=1, the block captures P_DATA, PAR_EN, PAR_TYP, STOP2 and the effective prescale Peff = max(Prescale,1).
  - Parity is computed from the captured data at capture time: even = XOR of data bits; odd = inverted XOR.
  - On that same edge: state goes to START, TX_OUT<=0, busy<=1. Latency from accepted Data_Valid to start-bit edge is 1 cycle.
- Bit timing:
  - Each bit is held for exactly Peff cycles.
  - The prescale counter runs 0..Peff-1. At Peff-1 the block advances to the next bit and the counter wraps to 0.
- START: after one bit time, go to DATA and drive data bit 0.
- DATA:
  - Bit index counts 0..DATA_WIDTH-1. The captured word is shifted right and bit 0 drives TX_OUT.
  - After the last data bit: go to PARITY if the captured PAR_EN=1, otherwise go to STOP.
- PARITY: drive the parity bit for one bit time, then go to STOP.
- STOP:
  - Drive TX_OUT=1 for 1 bit time, or 2 bit times if the captured STOP2=1.
  - On the edge that ends the final stop bit: state goes to IDLE, busy<=0, ser_done<=1 for exactly one cycle.
- Frame length: Peff × (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) cycles of busy=1.
- Back-to-back frames: Data_Valid may be accepted in the cycle where ser_done=1, because busy=0 in that cycle. The minimum start-to-start spacing is the frame length + 1 cycle, and the line is high for that gap cycle.
- Ignored inputs while busy=1:
  - Data_Valid is ignored; there is no queuing and no error flag.
  - Changes to P_DATA, PAR_EN, PAR_TYP, STOP2 and Prescale have no effect on the frame in flight.
- Output register: TX_OUT is driven from a flop, so the line never glitches.
- Counter widths:
  - Bit counter: ceil(log2(DATA_WIDTH+1)) bits.
  - Prescale counter: PRESCALE_WIDTH bits.
  - No overflow is possible at Prescale = all-ones.

Test Plan:
1. DATA_WIDTH=8, Prescale=4, PAR_EN=0, STOP2=0, P_DATA=0xA5 -> TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. busy high for 40 cycles. One ser_done pulse on the cycle after the stop bit ends.
2. P_DATA=0xA5, PAR_EN=1, Prescale=2 -> parity bit 0 with PAR_TYP=0 and 1 with PAR_TYP=1. Frame is 11 bits = 22 cycles.
3. STOP2=1, PAR_EN=1, P_DATA=0x00, PAR_TYP=1 -> parity bit 1, two stop bits, frame is 12 bits. Prescale=0 gives 12 cycles, identical to Prescale=1.
4. Data_Valid pulsed with P_DATA=0x3C mid-frame while busy=1 -> ignored. Only the original frame appears and no second ser_done occurs.
5. Data_Valid held high continuously with P_DATA=0x55 then 0x0F -> the second start bit begins exactly 1 cycle after the ser_done cycle, with one idle-high cycle between frames.
6. RST asserted during data bit 3 -> TX_OUT=1 and busy=0 immediately, ser_done never pulses. A new Data_Valid after RST deasserts produces a clean full frame.
